// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer for the execute stage.
// A radix-2 shift-add (multiply) or restoring shift-subtract (divide)
// datapath is shared by all M-extension ops and stalls EX while busy.
//
// Ports:
//   clock, reset   clock; synchronous active-high reset
//   start_i        request an operation (sampled only in IDLE)
//   funct3_i       M-extension funct3 (MUL..REMU)
//   word_i         W-variant select
//   srcA_i/srcB_i  rs1 / rs2 operands
//   flush_i        abort the current operation
//   stall_req_o    hold the pipeline (combinational)
//   busy_o         sequencer not idle
//   done_o         one-cycle pulse, result_o valid
//   result_o       registered result
module muldiv_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] srcA_i,
  input  logic [XLEN-1:0] srcB_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = 7;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_word;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;
  logic [XLEN-1:0] r_opb;

  // ---------------- accept-cycle operand preparation ----------------
  logic [2:0]      w_op;
  logic            w_is_div;
  logic            w_sgn_div;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec_res;
  logic [AW-1:0]   w_acc_init;

  always_comb begin
    w_is_div  = funct3_i[2];
    // Undefined W high-multiplies collapse onto MULW.
    w_op      = (word_i && !funct3_i[2]) ? F_MUL : funct3_i;
    w_sgn_div = funct3_i[2] & ~funct3_i[0];
    w_sgn_a   = (w_op == F_MULH) || (w_op == F_MULHSU) ||
                (w_op == F_DIV)  || (w_op == F_REM);
    w_sgn_b   = (w_op == F_MULH) || (w_op == F_DIV) || (w_op == F_REM);

    if (word_i) begin
      w_a_ext = w_sgn_div ? {{32{srcA_i[31]}}, srcA_i[31:0]} : {32'h0, srcA_i[31:0]};
      w_b_ext = w_sgn_div ? {{32{srcB_i[31]}}, srcB_i[31:0]} : {32'h0, srcB_i[31:0]};
    end else begin
      w_a_ext = srcA_i;
      w_b_ext = srcB_i;
    end

    w_sa    = w_sgn_a & w_a_ext[XLEN-1];
    w_sb    = w_sgn_b & w_b_ext[XLEN-1];
    w_mag_a = w_sa ? XLEN'(-w_a_ext) : w_a_ext;
    w_mag_b = w_sb ? XLEN'(-w_b_ext) : w_b_ext;

    case (w_op)
      F_MULH, F_MULHSU, F_DIV: w_neg = w_sa ^ w_sb;
      F_REM:                   w_neg = w_sa;
      default:                 w_neg = 1'b0;
    endcase

    w_div0 = w_is_div && (w_b_ext == '0);
    w_ovf  = w_is_div && w_sgn_div && (w_b_ext == '1) &&
             (word_i ? (w_a_ext == 64'hFFFF_FFFF_8000_0000)
                     : (w_a_ext == 64'h8000_0000_0000_0000));

    // funct3[1] distinguishes REM* from DIV*.
    if (w_div0) w_spec_raw = funct3_i[1] ? w_a_ext : '1;
    else        w_spec_raw = funct3_i[1] ? '0 : w_a_ext;
    w_spec_res = word_i ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;

    // W divides start with the dividend in the upper half of the low word
    // so 32 shifts move it fully into the remainder half.
    if (w_is_div && word_i) w_acc_init = {64'h0, w_mag_a[31:0], 32'h0};
    else                    w_acc_init = {64'h0, w_mag_a};
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]   w_sum;
  logic [AW-1:0]   w_mul_nxt;
  logic [XLEN+1:0] w_diff;
  logic            w_take;
  logic [AW-1:0]   w_div_nxt;

  always_comb begin
    w_sum     = {1'b0, r_acc[AW-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : (XLEN+1)'(0));
    w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
    // 65-bit shifted partial remainder minus divisor; top two bits zero
    // means the subtraction fits and a quotient 1 is produced.
    w_diff    = {1'b0, r_acc[AW-1:XLEN-1]} - {2'b00, r_opb};
    w_take    = (w_diff[XLEN+1:XLEN] == 2'b00);
    w_div_nxt = w_take ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                       : {r_acc[AW-2:0], 1'b0};
  end

  // ---------------- sign fix-up and result select ----------------
  logic [AW-1:0]   w_acc_neg;
  logic [XLEN-1:0] w_lo;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix_raw;
  logic [XLEN-1:0] w_fix_res;

  always_comb begin
    w_acc_neg = AW'(-r_acc);
    w_lo      = r_neg ? w_acc_neg[XLEN-1:0] : r_acc[XLEN-1:0];
    w_hi      = r_neg ? w_acc_neg[AW-1:XLEN] : r_acc[AW-1:XLEN];
    w_rem     = r_neg ? XLEN'(-r_acc[AW-1:XLEN]) : r_acc[AW-1:XLEN];
    case (r_op)
      // After 32 iterations the W product sits in acc[127:32].
      F_MUL:                      w_fix_raw = r_word ? {32'h0, r_acc[63:32]} : r_acc[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  w_fix_raw = w_hi;
      F_DIV, F_DIVU:              w_fix_raw = w_lo;
      F_REM, F_REMU:              w_fix_raw = w_rem;
      default:                    w_fix_raw = w_lo;
    endcase
    w_fix_res = r_word ? {{32{w_fix_raw[31]}}, w_fix_raw[31:0]} : w_fix_raw;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b000;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            r_op   <= w_op;
            r_word <= word_i;
            r_neg  <= w_neg;
            r_cnt  <= word_i ? CW'(32) : CW'(64);
            r_acc  <= w_acc_init;
            r_opb  <= w_mag_b;
            if (w_div0 || w_ovf) begin
              result_o <= w_spec_res;
              done_o   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            result_o <= w_fix_res;
            done_o   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign stall_req_o = ((r_state == S_IDLE) && start_i && !flush_i) ||
                       (r_state == S_CALC) || (r_state == S_FIX);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq.
module tb_muldiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic        word_i;
  logic [63:0] srcA_i;
  logic [63:0] srcB_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;

  int n_total = 0;
  int n_bad   = 0;

  muldiv_seq #(.XLEN(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_i     (start_i),
    .funct3_i    (funct3_i),
    .word_i      (word_i),
    .srcA_i      (srcA_i),
    .srcB_i      (srcB_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of accept+1.
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    funct3_i = f3; word_i = w; srcA_i = a; srcB_i = b; start_i = 1'b1;
    #1;
    chk("stall_accept", 64'(stall_req_o), 64'd1);
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output logic [63:0] res, output int lat,
                           output bit stall_ok);
    lat = lat0;
    stall_ok = 1'b1;
    while (!done_o && lat < 200) begin
      if (!stall_req_o) stall_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    chk("done_seen", 64'(done_o), 64'd1);
    chk("stall_low_in_done", 64'(stall_req_o), 64'd0);
    res = result_o;
    @(negedge clock);
    chk("done_one_cycle", 64'(done_o), 64'd0);
    chk("result_hold", result_o, res);
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int lat;
    bit sok;
    issue(f3, w, a, b);
    wait_done(1, res, lat, sok);
    chk(tag, res, exp);
    if (exp_lat != 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall"}, 64'(sok), 64'd1);
  endtask

  initial begin
    logic [63:0] res;
    int lat;
    bit sok;
    int seen;

    reset = 1'b1; start_i = 1'b0; funct3_i = 3'b000; word_i = 1'b0;
    srcA_i = '0; srcB_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run("mul",    3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    run("mulhu",  3'b011, 1'b0, '1, 64'd2, 64'd1, 66);
    run("mulh",   3'b001, 1'b0, '1, '1, 64'd0, 66);
    run("mulhsu", 3'b010, 1'b0, '1, 64'd2, '1, 66);
    run("div",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run("rem",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66);
    run("divu",   3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 66);

    run("div_by0",  3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, '1, 1);
    run("remu_by0", 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run("div_ovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

    // 32-bit most-negative / -1 is a W overflow case; only the value is checked.
    run("divw_ovf", 3'b100, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
    run("divuw",    3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 34);
    run("mulw",     3'b000, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 34);
    run("divw",     3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);

    // Flush mid-calculation.
    issue(3'b000, 1'b0, '1, 64'd12345);
    repeat (9) @(negedge clock);
    flush_i = 1'b1;
    @(negedge clock);
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_done", 64'(done_o), 64'd0);
    chk("flush_result", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (done_o) seen++;
      @(negedge clock);
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    run("mul_after_flush", 3'b000, 1'b0, 64'd3, 64'd4, 64'd12, 66);

    // Flush beats start in IDLE.
    funct3_i = 3'b000; word_i = 1'b0; srcA_i = 64'd2; srcB_i = 64'd2;
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("flush_start_stall", 64'(stall_req_o), 64'd0);
    @(negedge clock);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", 64'(busy_o), 64'd0);

    // Reset mid-operation.
    issue(3'b101, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_stall", 64'(stall_req_o), 64'd0);
    @(negedge clock);

    // Start during CALC is ignored.
    issue(3'b101, 1'b0, 64'd100, 64'd7);
    repeat (4) @(negedge clock);
    funct3_i = 3'b000; srcA_i = 64'd3; srcB_i = 64'd3; start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    wait_done(6, res, lat, sok);
    chk("busy_start_result", res, 64'd14);
    chk("busy_start_lat", 64'(lat), 64'd66);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
